// File: rtl/fft_peak_detect.sv
// fft_peak_detect: captures a 16-bin complex spectrum, scans one bin per cycle
// for the largest re^2+im^2 and reports its index on freq with a done pulse.
// A single pending bank buffers a frame arriving mid-scan; losing a pending
// frame sets the sticky overrun flag.
module fft_peak_detect #(
  parameter bit DC_EXCLUDE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fft_valid,
  input  logic [31:0] fft_d0,
  input  logic [31:0] fft_d1,
  input  logic [31:0] fft_d2,
  input  logic [31:0] fft_d3,
  input  logic [31:0] fft_d4,
  input  logic [31:0] fft_d5,
  input  logic [31:0] fft_d6,
  input  logic [31:0] fft_d7,
  input  logic [31:0] fft_d8,
  input  logic [31:0] fft_d9,
  input  logic [31:0] fft_d10,
  input  logic [31:0] fft_d11,
  input  logic [31:0] fft_d12,
  input  logic [31:0] fft_d13,
  input  logic [31:0] fft_d14,
  input  logic [31:0] fft_d15,
  output logic        done,
  output logic [3:0]  freq,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [31:0] in_bank [16];
  logic [31:0] w_bank  [16];
  logic [31:0] p_bank  [16];

  logic        pend;
  logic [3:0]  idx;
  logic [31:0] max_mag;
  logic [3:0]  max_idx;

  logic        load_w_in;
  logic        load_w_pend;
  logic        load_p;
  logic        set_pend;
  logic        clr_pend;
  logic        set_ovr;
  logic        start_scan;

  logic [31:0] scan_bin;
  logic [31:0] cur_mag;
  logic        better;

  // Squared magnitude of one bin. Both squares are at most 2^30 (from -32768),
  // so the 32-bit unsigned sum peaks at 2^31 and cannot wrap.
  function automatic logic [31:0] bin_mag(input logic [31:0] bin);
    logic signed [31:0] re_x;
    logic signed [31:0] im_x;
    logic signed [31:0] re_sq;
    logic signed [31:0] im_sq;
    re_x  = {{16{bin[31]}}, bin[31:16]};
    im_x  = {{16{bin[15]}}, bin[15:0]};
    re_sq = re_x * re_x;
    im_sq = im_x * im_x;
    return $unsigned(re_sq) + $unsigned(im_sq);
  endfunction

  // Gather the individual bin ports into an indexable bank image.
  always_comb begin
    in_bank[0]  = fft_d0;
    in_bank[1]  = fft_d1;
    in_bank[2]  = fft_d2;
    in_bank[3]  = fft_d3;
    in_bank[4]  = fft_d4;
    in_bank[5]  = fft_d5;
    in_bank[6]  = fft_d6;
    in_bank[7]  = fft_d7;
    in_bank[8]  = fft_d8;
    in_bank[9]  = fft_d9;
    in_bank[10] = fft_d10;
    in_bank[11] = fft_d11;
    in_bank[12] = fft_d12;
    in_bank[13] = fft_d13;
    in_bank[14] = fft_d14;
    in_bank[15] = fft_d15;
  end

  // Magnitude of the bin under the scan pointer and whether it beats the
  // running maximum (strictly greater, so ties keep the lower index).
  always_comb begin
    scan_bin = w_bank[idx];
    if (DC_EXCLUDE && (idx == 4'd0)) begin
      cur_mag = 32'd0;
    end else begin
      cur_mag = bin_mag(scan_bin);
    end
    better = (idx != 4'd0) && (cur_mag > max_mag);
  end

  // Next-state and bank-steering decisions.
  always_comb begin
    state_nxt   = state;
    load_w_in   = 1'b0;
    load_w_pend = 1'b0;
    load_p      = 1'b0;
    set_pend    = 1'b0;
    clr_pend    = 1'b0;
    set_ovr     = 1'b0;
    case (state)
      S_IDLE: begin
        if (fft_valid) begin
          load_w_in = 1'b1;
          state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        // The working bank stays frozen; a new frame parks in the pending bank.
        if (fft_valid) begin
          load_p   = 1'b1;
          set_pend = 1'b1;
          set_ovr  = pend;
        end
        if (idx == 4'd15) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (fft_valid) begin
          // A fresh frame wins over a parked one, which is then lost.
          load_w_in = 1'b1;
          clr_pend  = pend;
          set_ovr   = pend;
          state_nxt = S_SCAN;
        end else if (pend) begin
          load_w_pend = 1'b1;
          clr_pend    = 1'b1;
          state_nxt   = S_SCAN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign start_scan = load_w_in | load_w_pend;

  // Control state: FSM, scan pointer, running maximum and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      freq    <= 4'd0;
      overrun <= 1'b0;
      pend    <= 1'b0;
      idx     <= 4'd0;
      max_mag <= 32'd0;
      max_idx <= 4'd0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != S_IDLE);
      done  <= 1'b0;

      if (start_scan) begin
        idx <= 4'd0;
      end else if (state == S_SCAN) begin
        idx <= idx + 4'd1;
      end

      if (state == S_SCAN) begin
        if (idx == 4'd0) begin
          max_mag <= cur_mag;
          max_idx <= 4'd0;
        end else if (better) begin
          max_mag <= cur_mag;
          max_idx <= idx;
        end
        // The last bin is folded into the result directly so freq and done
        // appear together on the cycle the FSM enters DONE.
        if (idx == 4'd15) begin
          done <= 1'b1;
          freq <= better ? idx : max_idx;
        end
      end

      if (set_pend) begin
        pend <= 1'b1;
      end else if (clr_pend) begin
        pend <= 1'b0;
      end

      if (set_ovr) begin
        overrun <= 1'b1;
      end
    end
  end

  // Spectrum storage; data only, so no reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 16; k++) begin
      if (load_w_in) begin
        w_bank[k] <= in_bank[k];
      end else if (load_w_pend) begin
        w_bank[k] <= p_bank[k];
      end
      if (load_p) begin
        p_bank[k] <= in_bank[k];
      end
    end
  end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Testbench for fft_peak_detect: directed spectra with literal expectations
// plus randomized frame traffic checked every cycle against a frame-level model.
`timescale 1ns/1ps
module tb_fft_peak_detect;

  logic        clk;
  logic        rst;
  logic        fft_valid;
  logic [31:0] d [16];

  logic        done,  done_n;
  logic [3:0]  freq,  freq_n;
  logic        busy,  busy_n;
  logic        overrun, overrun_n;

  int n_checks;
  int n_fail;
  bit chk_en;

  // DUT with DC bin excluded (default)
  fft_peak_detect dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(d[0]),   .fft_d1(d[1]),   .fft_d2(d[2]),   .fft_d3(d[3]),
    .fft_d4(d[4]),   .fft_d5(d[5]),   .fft_d6(d[6]),   .fft_d7(d[7]),
    .fft_d8(d[8]),   .fft_d9(d[9]),   .fft_d10(d[10]), .fft_d11(d[11]),
    .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
    .done(done), .freq(freq), .busy(busy), .overrun(overrun)
  );

  // DUT with DC bin included
  fft_peak_detect #(.DC_EXCLUDE(1'b0)) dut_dc (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(d[0]),   .fft_d1(d[1]),   .fft_d2(d[2]),   .fft_d3(d[3]),
    .fft_d4(d[4]),   .fft_d5(d[5]),   .fft_d6(d[6]),   .fft_d7(d[7]),
    .fft_d8(d[8]),   .fft_d9(d[9]),   .fft_d10(d[10]), .fft_d11(d[11]),
    .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
    .done(done_n), .freq(freq_n), .busy(busy_n), .overrun(overrun_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Peak index straight from the definition: largest re^2+im^2, lowest index on ties.
  function automatic logic [3:0] peak_of(input logic [31:0] f [16], input bit dc_ex);
    longint best;
    longint mag;
    shortint re;
    shortint im;
    logic [3:0] bi;
    best = -1;
    bi = 4'd0;
    for (int k = 0; k < 16; k++) begin
      re = f[k][31:16];
      im = f[k][15:0];
      mag = longint'(re) * longint'(re) + longint'(im) * longint'(im);
      if (dc_ex && k == 0) mag = 0;
      if (mag > best) begin
        best = mag;
        bi = 4'(k);
      end
    end
    return bi;
  endfunction

  // Frame-level reference: each accepted frame's answer is computed on arrival;
  // a scan occupies 16 cycles followed by a one-cycle result slot.
  bit         m_scanning, m_done, m_pend, m_ovr;
  int         m_cnt;
  logic [3:0] m_f1, m_f0, cur1, cur0, pend1, pend0;

  initial begin
    m_scanning = 0; m_done = 0; m_pend = 0; m_ovr = 0; m_cnt = 0;
    m_f1 = 0; m_f0 = 0; cur1 = 0; cur0 = 0; pend1 = 0; pend0 = 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_scanning <= 0; m_done <= 0; m_pend <= 0; m_ovr <= 0;
      m_cnt <= 0; m_f1 <= 0; m_f0 <= 0;
    end else if (m_done) begin
      m_done <= 0;
      if (fft_valid) begin
        m_scanning <= 1; m_cnt <= 16;
        cur1 <= peak_of(d, 1'b1); cur0 <= peak_of(d, 1'b0);
        if (m_pend) begin
          m_ovr <= 1; m_pend <= 0;
        end
      end else if (m_pend) begin
        m_scanning <= 1; m_cnt <= 16;
        cur1 <= pend1; cur0 <= pend0; m_pend <= 0;
      end
    end else if (m_scanning) begin
      if (fft_valid) begin
        pend1 <= peak_of(d, 1'b1); pend0 <= peak_of(d, 1'b0);
        m_pend <= 1;
        if (m_pend) m_ovr <= 1;
      end
      if (m_cnt == 1) begin
        m_scanning <= 0; m_done <= 1; m_f1 <= cur1; m_f0 <= cur0;
      end
      m_cnt <= m_cnt - 1;
    end else if (fft_valid) begin
      m_scanning <= 1; m_cnt <= 16;
      cur1 <= peak_of(d, 1'b1); cur0 <= peak_of(d, 1'b0);
    end
  end

  // Cycle-by-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("done",      {31'd0, done},      {31'd0, m_done});
      check("freq",      {28'd0, freq},      {28'd0, m_f1});
      check("busy",      {31'd0, busy},      {31'd0, m_scanning | m_done});
      check("overrun",   {31'd0, overrun},   {31'd0, m_ovr});
      check("dc_done",   {31'd0, done_n},    {31'd0, m_done});
      check("dc_freq",   {28'd0, freq_n},    {28'd0, m_f0});
      check("dc_busy",   {31'd0, busy_n},    {31'd0, m_scanning | m_done});
      check("dc_overrun",{31'd0, overrun_n}, {31'd0, m_ovr});
    end
  end

  task automatic clear_d(input logic [31:0] v);
    for (int k = 0; k < 16; k++) d[k] = v;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present the current d[] for one sampling edge.
  task automatic send();
    fft_valid = 1'b1;
    @(posedge clk);
    #1;
    fft_valid = 1'b0;
  endtask

  // Count negedges until done is seen; cyc = 0 on timeout.
  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: no done within 40 cycles at %0t", $time);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int ndone;
    n_checks = 0;
    n_fail = 0;
    chk_en = 0;
    rst = 1'b1;
    fft_valid = 1'b0;
    clear_d(32'd0);
    idle(3);
    chk_en = 1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_freq", {28'd0, freq}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    @(posedge clk); #1;

    // Single tone in bin 1
    clear_d(32'd0);
    d[1] = 32'h0400_0000;
    check("model_tone", {28'd0, peak_of(d, 1'b1)}, 32'd1);
    send();
    wait_done(cyc);
    check("tone_latency", cyc, 32'd17);
    check("tone_freq", {28'd0, freq}, 32'd1);
    @(negedge clk);
    check("tone_busy_low", {31'd0, busy}, 32'd0);
    check("tone_done_low", {31'd0, done}, 32'd0);
    idle(2);

    // Equal magnitudes in bins 1 and 15 keep the lower index
    clear_d(32'h0000_0001);
    d[1]  = 32'h0300_FD00;
    d[15] = 32'h0300_FD00;
    check("model_tie", {28'd0, peak_of(d, 1'b1)}, 32'd1);
    send();
    wait_done(cyc);
    check("tie_freq", {28'd0, freq}, 32'd1);
    idle(3);
    d[15] = 32'h0301_FD00;
    send();
    wait_done(cyc);
    check("tie_break_freq", {28'd0, freq}, 32'd15);
    idle(3);

    // DC exclusion
    clear_d(32'd0);
    d[0] = 32'h7FFF_0000;
    d[7] = 32'h0100_0000;
    check("model_dc_ex", {28'd0, peak_of(d, 1'b1)}, 32'd7);
    check("model_dc_in", {28'd0, peak_of(d, 1'b0)}, 32'd0);
    send();
    wait_done(cyc);
    check("dc_excl_freq", {28'd0, freq}, 32'd7);
    check("dc_incl_freq", {28'd0, freq_n}, 32'd0);
    idle(3);

    // Width extremes: 2^31 must beat 2*(32767^2)
    clear_d(32'd0);
    d[9] = 32'h8000_8000;
    d[3] = 32'h7FFF_7FFF;
    check("model_extreme", {28'd0, peak_of(d, 1'b1)}, 32'd9);
    send();
    wait_done(cyc);
    check("extreme_freq", {28'd0, freq}, 32'd9);
    check("extreme_freq_dc", {28'd0, freq_n}, 32'd9);
    idle(3);

    // Pending frame without overrun: A (peak 2), B (peak 5) five cycles later
    clear_d(32'd0); d[2] = 32'h0100_0000;
    send();
    idle(4);
    clear_d(32'd0); d[5] = 32'h0100_0000;
    send();
    wait_done(cyc);
    check("pend_a_freq", {28'd0, freq}, 32'd2);
    wait_done(cyc);
    check("pend_b_gap", cyc, 32'd17);
    check("pend_b_freq", {28'd0, freq}, 32'd5);
    check("pend_no_ovr", {31'd0, overrun}, 32'd0);
    idle(3);

    // Overrun: C (peak 11) three cycles after B overwrites B
    clear_d(32'd0); d[2] = 32'h0100_0000;
    send();
    idle(4);
    clear_d(32'd0); d[5] = 32'h0100_0000;
    send();
    idle(2);
    clear_d(32'd0); d[11] = 32'h0100_0000;
    send();
    wait_done(cyc);
    check("ovr_a_freq", {28'd0, freq}, 32'd2);
    wait_done(cyc);
    check("ovr_gap", cyc, 32'd17);
    check("ovr_c_freq", {28'd0, freq}, 32'd11);
    check("ovr_flag", {31'd0, overrun}, 32'd1);
    idle(3);

    // Reset eight cycles into a scan
    clear_d(32'd0); d[4] = 32'h0200_0000;
    send();
    idle(7);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mrst_done", {31'd0, done}, 32'd0);
    check("mrst_freq", {28'd0, freq}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_overrun", {31'd0, overrun}, 32'd0);
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("mrst_no_done", ndone, 32'd0);
    @(posedge clk); #1;
    clear_d(32'd0); d[13] = 32'hFF00_0080;
    send();
    wait_done(cyc);
    check("mrst_after_latency", cyc, 32'd17);
    check("mrst_after_freq", {28'd0, freq}, 32'd13);
    idle(3);

    // Randomized traffic, compared every cycle against the model
    for (int n = 0; n < 300; n++) begin
      int mode;
      mode = $urandom_range(0, 3);
      if (mode == 0) begin
        for (int k = 0; k < 16; k++) d[k] = $urandom;
      end else if (mode == 1) begin
        for (int k = 0; k < 16; k++) d[k] = {8'($urandom_range(0, 255)) << 4 >> 4, 8'd0, 16'($urandom_range(0, 255))};
        d[$urandom_range(0, 15)] = {16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535))};
      end else if (mode == 2) begin
        for (int k = 0; k < 16; k++) d[k] = {16'($urandom_range(0, 7)), 16'($urandom_range(0, 7))};
        d[$urandom_range(0, 15)] = d[$urandom_range(0, 15)];
      end else begin
        clear_d(32'd0);
        d[$urandom_range(0, 15)] = $urandom;
        d[$urandom_range(0, 15)] = $urandom;
      end
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
      end
      send();
      idle($urandom_range(0, 24));
    end
    idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
